// File: rtl/topk_stream_sorter.sv
// Streaming top-K selector: parallel compare-and-swap cells keep the K best samples sorted, then drain them.
// Optional TOPK_DEDUP_EN: samples equal to an occupied cell are accepted but not inserted.
module topk_stream_sorter #(
    parameter int DATA_W  = 16,
    parameter int K       = 8,
    parameter int DESCEND = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [$clog2(K+1)-1:0]    out_count
);

    localparam int CNT_W = $clog2(K+1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] val_q [K];
    logic signed [DATA_W-1:0] val_d [K];
    logic [K-1:0]             occ_q, occ_d;

    logic signed [DATA_W-1:0] prev_val [K];
    logic signed [DATA_W-1:0] next_val [K];
    logic [K-1:0]             prev_occ, next_occ;
    logic signed [DATA_W-1:0] sample;
    logic                     dup;
    logic                     ins_en;
    logic                     new_fits;
    logic                     prev_beaten;
    logic                     above_ok;

    function automatic logic beats(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
        if (DESCEND != 0) return a > b;
        else              return a < b;
    endfunction

    assign sample = in_data;

    // Neighbour views of the cell array: prev feeds insertion shifts, next feeds drain shifts.
    always_comb begin
        prev_val[0] = '0;
        next_val[K-1] = '0;
        for (int i = 1; i < K; i++) prev_val[i] = val_q[i-1];
        for (int i = 0; i < K-1; i++) next_val[i] = val_q[i+1];
        prev_occ = {occ_q[K-2:0], 1'b0};
        next_occ = {1'b0, occ_q[K-1:1]};
    end

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (occ_q[i] && (val_q[i] == sample)) dup = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        val_d       = val_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        ins_en      = 1'b0;
        new_fits    = 1'b0;
        prev_beaten = 1'b0;
        above_ok    = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef TOPK_DEDUP_EN
                    ins_en = !dup;
`else
                    ins_en = 1'b1;
`endif
                    if (ins_en) begin
                        // Strict compare places a new sample after equal values (stable ties).
                        for (int i = 0; i < K; i++) begin
                            new_fits    = !occ_q[i] || beats(sample, val_q[i]);
                            prev_beaten = prev_occ[i] && beats(sample, prev_val[i]);
                            above_ok    = (i == 0) || (prev_occ[i] && !beats(sample, prev_val[i]));
                            if (new_fits && above_ok) begin
                                val_d[i] = sample;
                                occ_d[i] = 1'b1;
                            end else if (prev_beaten) begin
                                val_d[i] = prev_val[i];
                                occ_d[i] = 1'b1;
                            end
                        end
                    end
                    if (in_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = occ_q[0];
                out_last  = occ_q[0] && !occ_q[1];
                out_data  = val_q[0];
                if (out_valid && out_ready) begin
                    for (int i = 0; i < K; i++) val_d[i] = next_val[i];
                    occ_d = next_occ;
                    if (out_last) state_d = FILL;
                end
                // An empty array cannot produce out_last, so never sit in DRAIN with nothing to send.
                if (!occ_q[0]) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        out_count = '0;
        for (int i = 0; i < K; i++) out_count = out_count + CNT_W'(occ_q[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            occ_q   <= '0;
            for (int i = 0; i < K; i++) val_q[i] <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            for (int i = 0; i < K; i++) val_q[i] <= val_d[i];
        end
    end

endmodule
